// File: rtl/punc_control_fsm_pkg.sv
// Shared encodings for the PUnC control FSM: states, LC3 opcodes, datapath select codes.
// Pure definitions, no logic or latency; nothing here carries handshake or backpressure.
// Also holds the per-opcode control bundle exchanged between decoder and FSM.
package punc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_EXEC2  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] MEM_ADDR_PC    = 2'b00;
    localparam logic [1:0] MEM_ADDR_ALU   = 2'b01;
    localparam logic [1:0] MEM_ADDR_STORE = 2'b10;

    localparam logic [1:0] RF_W_PC  = 2'b00;
    localparam logic [1:0] RF_W_MEM = 2'b01;
    localparam logic [1:0] RF_W_ALU = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_AND    = 2'b01;
    localparam logic [1:0] ALU_PASS_A = 2'b10;
    localparam logic [1:0] ALU_NOT    = 2'b11;

    localparam logic [1:0] IMM_5  = 2'b00;
    localparam logic [1:0] IMM_6  = 2'b01;
    localparam logic [1:0] IMM_9  = 2'b10;
    localparam logic [1:0] IMM_11 = 2'b11;

    localparam logic A_SEL_PC     = 1'b0;
    localparam logic A_SEL_RF     = 1'b1;
    localparam logic B_SEL_RF     = 1'b0;
    localparam logic B_SEL_IMM    = 1'b1;
    localparam logic PC_DATA_OFF  = 1'b0;
    localparam logic PC_DATA_ALU  = 1'b1;
    localparam logic PC_ADD_OFF11 = 1'b0;
    localparam logic PC_ADD_OFF9  = 1'b1;
    localparam logic NZP_SEL_ALU  = 1'b0;
    localparam logic NZP_SEL_MEM  = 1'b1;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_data_sel;
        logic       pc_add_sel;
        logic [1:0] mem_addr_sel;
        logic       store_ld;
        logic       mem_w_en;
        logic       rf_w_en;
        logic [1:0] rf_w_sel;
        logic [2:0] rf_r_addr_0;
        logic [2:0] rf_r_addr_1;
        logic [2:0] rf_w_addr;
        logic       a_sel;
        logic       b_sel;
        logic [1:0] imm_sel;
        logic [1:0] alu_sel;
        logic       nzp_ld;
        logic       nzp_sel;
        logic       two_phase;
        logic       halt;
    } ctrl_t;

    function automatic logic br_taken(input logic [2:0] cond, input logic [2:0] nzp);
        return |(cond & nzp);
    endfunction

endpackage

// File: rtl/punc_control_fsm_if.sv
// Control/status bundle between the PUnC controller (master) and its datapath (slave).
// Wires only, zero latency; no handshake, the datapath obeys strobes unconditionally.
// The datapath returns IR and comparator flags; everything else flows toward it.
interface punc_control_fsm_if;
    logic [15:0] ir;
    logic        cmp_n;
    logic        cmp_z;
    logic        cmp_p;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_inc;
    logic        ir_ld;
    logic        store_ld;
    logic        mem_w_en;
    logic        rf_w_en;
    logic        nzp_ld_dp;
    logic        pc_data_sel;
    logic        pc_add_sel;
    logic [1:0]  mem_addr_sel;
    logic [1:0]  rf_w_sel;
    logic [2:0]  rf_r_addr_0;
    logic [2:0]  rf_r_addr_1;
    logic [2:0]  rf_w_addr;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  imm_sel;
    logic [1:0]  alu_sel;
    logic        nzp_sel;
    logic [2:0]  nzp;
    logic        halted;

    modport master (
        input  ir, cmp_n, cmp_z, cmp_p,
        output pc_ld, pc_clr, pc_inc, ir_ld, store_ld, mem_w_en, rf_w_en, nzp_ld_dp,
        output pc_data_sel, pc_add_sel, mem_addr_sel, rf_w_sel,
        output rf_r_addr_0, rf_r_addr_1, rf_w_addr,
        output a_sel, b_sel, imm_sel, alu_sel, nzp_sel, nzp, halted
    );

    modport slave (
        output ir, cmp_n, cmp_z, cmp_p,
        input  pc_ld, pc_clr, pc_inc, ir_ld, store_ld, mem_w_en, rf_w_en, nzp_ld_dp,
        input  pc_data_sel, pc_add_sel, mem_addr_sel, rf_w_sel,
        input  rf_r_addr_0, rf_r_addr_1, rf_w_addr,
        input  a_sel, b_sel, imm_sel, alu_sel, nzp_sel, nzp, halted
    );
endinterface

// File: rtl/punc_control_fsm_decode.sv
// Instruction decoder: maps IR (and current NZP for branches) to EXEC and EXEC2 control bundles.
// Purely combinational, zero latency; no backpressure, the FSM decides when a bundle applies.
// Bundles carry two_phase (go to EXEC2) and halt flags for next-state selection.
module punc_ctrl_decode
    import punc_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    output ctrl_t       exec_ctrl,
    output ctrl_t       exec2_ctrl
);

    logic [3:0] op;
    assign op = ir[15:12];

    always_comb begin
        exec_ctrl  = '0;
        exec2_ctrl = '0;
        exec2_ctrl.mem_addr_sel = MEM_ADDR_STORE;

        case (op)
            OP_ADD, OP_AND, OP_NOT: begin
                exec_ctrl.rf_r_addr_0 = ir[8:6];
                exec_ctrl.a_sel       = A_SEL_RF;
                if (op == OP_NOT) begin
                    exec_ctrl.alu_sel = ALU_NOT;
                end else begin
                    exec_ctrl.alu_sel = (op == OP_AND) ? ALU_AND : ALU_ADD;
                    if (ir[5]) begin
                        exec_ctrl.b_sel   = B_SEL_IMM;
                        exec_ctrl.imm_sel = IMM_5;
                    end else begin
                        exec_ctrl.rf_r_addr_1 = ir[2:0];
                    end
                end
                exec_ctrl.rf_w_sel  = RF_W_ALU;
                exec_ctrl.rf_w_addr = ir[11:9];
                exec_ctrl.rf_w_en   = 1'b1;
                exec_ctrl.nzp_sel   = NZP_SEL_ALU;
                exec_ctrl.nzp_ld    = 1'b1;
            end
            OP_BR: begin
                if (br_taken(ir[11:9], nzp)) begin
                    exec_ctrl.pc_ld       = 1'b1;
                    exec_ctrl.pc_data_sel = PC_DATA_OFF;
                    exec_ctrl.pc_add_sel  = PC_ADD_OFF9;
                end
            end
            OP_JMP: begin
                exec_ctrl.rf_r_addr_0 = ir[8:6];
                exec_ctrl.a_sel       = A_SEL_RF;
                exec_ctrl.alu_sel     = ALU_PASS_A;
                exec_ctrl.pc_data_sel = PC_DATA_ALU;
                exec_ctrl.pc_ld       = 1'b1;
            end
            OP_JSR: begin
                // R7 write and PC load share one edge, so R7 sees the incremented PC.
                exec_ctrl.rf_w_sel  = RF_W_PC;
                exec_ctrl.rf_w_addr = 3'd7;
                exec_ctrl.rf_w_en   = 1'b1;
                exec_ctrl.pc_ld     = 1'b1;
                if (ir[11]) begin
                    exec_ctrl.pc_add_sel  = PC_ADD_OFF11;
                    exec_ctrl.pc_data_sel = PC_DATA_OFF;
                end else begin
                    exec_ctrl.rf_r_addr_0 = ir[8:6];
                    exec_ctrl.a_sel       = A_SEL_RF;
                    exec_ctrl.alu_sel     = ALU_PASS_A;
                    exec_ctrl.pc_data_sel = PC_DATA_ALU;
                end
            end
            OP_LD, OP_LDR, OP_ST, OP_STR: begin
                exec_ctrl.b_sel        = B_SEL_IMM;
                exec_ctrl.alu_sel      = ALU_ADD;
                exec_ctrl.mem_addr_sel = MEM_ADDR_ALU;
                if (op == OP_LDR || op == OP_STR) begin
                    exec_ctrl.a_sel       = A_SEL_RF;
                    exec_ctrl.rf_r_addr_0 = ir[8:6];
                    exec_ctrl.imm_sel     = IMM_6;
                end else begin
                    exec_ctrl.a_sel   = A_SEL_PC;
                    exec_ctrl.imm_sel = IMM_9;
                end
                if (op == OP_LD || op == OP_LDR) begin
                    exec_ctrl.rf_w_sel  = RF_W_MEM;
                    exec_ctrl.rf_w_addr = ir[11:9];
                    exec_ctrl.rf_w_en   = 1'b1;
                    exec_ctrl.nzp_sel   = NZP_SEL_MEM;
                    exec_ctrl.nzp_ld    = 1'b1;
                end else begin
                    exec_ctrl.rf_r_addr_1 = ir[11:9];
                    exec_ctrl.mem_w_en    = 1'b1;
                end
            end
            OP_LEA: begin
                exec_ctrl.a_sel     = A_SEL_PC;
                exec_ctrl.b_sel     = B_SEL_IMM;
                exec_ctrl.imm_sel   = IMM_9;
                exec_ctrl.alu_sel   = ALU_ADD;
                exec_ctrl.rf_w_sel  = RF_W_ALU;
                exec_ctrl.rf_w_addr = ir[11:9];
                exec_ctrl.rf_w_en   = 1'b1;
            end
            OP_LDI, OP_STI: begin
                exec_ctrl.a_sel        = A_SEL_PC;
                exec_ctrl.b_sel        = B_SEL_IMM;
                exec_ctrl.imm_sel      = IMM_9;
                exec_ctrl.alu_sel      = ALU_ADD;
                exec_ctrl.mem_addr_sel = MEM_ADDR_ALU;
                exec_ctrl.store_ld     = 1'b1;
                exec_ctrl.two_phase    = 1'b1;
                if (op == OP_LDI) begin
                    exec2_ctrl.rf_w_sel  = RF_W_MEM;
                    exec2_ctrl.rf_w_addr = ir[11:9];
                    exec2_ctrl.rf_w_en   = 1'b1;
                    exec2_ctrl.nzp_sel   = NZP_SEL_MEM;
                    exec2_ctrl.nzp_ld    = 1'b1;
                end else begin
                    exec2_ctrl.rf_r_addr_1 = ir[11:9];
                    exec2_ctrl.mem_w_en    = 1'b1;
                end
            end
            OP_TRAP: exec_ctrl.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/punc_control_fsm.sv
// PUnC LC3 multi-cycle controller: FETCH/DECODE/EXEC[/EXEC2] sequencing, NZP register, branch decision.
// Latency: 3 cycles per instruction, 4 for LDI/STI; strobes are combinational from state and IR.
// No backpressure: the datapath must act on every strobe. PUNC_INSTR_COUNT_EN adds retired_count.
module punc_control_fsm
    import punc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    punc_control_fsm_if.master     dp
`ifdef PUNC_INSTR_COUNT_EN
    ,
    output logic [31:0]            retired_count
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] nzp_q;
    ctrl_t      exec_c;
    ctrl_t      exec2_c;
    ctrl_t      ctrl;
    logic       pc_clr;
    logic       ir_ld;
    logic       pc_inc;

    punc_ctrl_decode u_decode (
        .ir         (dp.ir),
        .nzp        (nzp_q),
        .exec_ctrl  (exec_c),
        .exec2_ctrl (exec2_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            if (ctrl.nzp_ld) begin
                nzp_q <= {dp.cmp_n, dp.cmp_z, dp.cmp_p};
            end
        end
    end

    // Reset masks every strobe except pc_clr, so an in-flight write is dropped.
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        pc_clr  = 1'b0;
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        if (rst) begin
            pc_clr  = 1'b1;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    ctrl.mem_addr_sel = MEM_ADDR_PC;
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
                ST_DECODE: state_d = ST_EXEC;
                ST_EXEC: begin
                    ctrl = exec_c;
                    if (ctrl.halt) begin
                        state_d = ST_HALT;
                    end else if (ctrl.two_phase) begin
                        state_d = ST_EXEC2;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_EXEC2: begin
                    ctrl    = exec2_c;
                    state_d = ST_FETCH;
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    assign dp.pc_clr       = pc_clr;
    assign dp.ir_ld        = ir_ld;
    assign dp.pc_inc       = pc_inc;
    assign dp.pc_ld        = ctrl.pc_ld;
    assign dp.store_ld     = ctrl.store_ld;
    assign dp.mem_w_en     = ctrl.mem_w_en;
    assign dp.rf_w_en      = ctrl.rf_w_en;
    assign dp.nzp_ld_dp    = ctrl.nzp_ld;
    assign dp.pc_data_sel  = ctrl.pc_data_sel;
    assign dp.pc_add_sel   = ctrl.pc_add_sel;
    assign dp.mem_addr_sel = ctrl.mem_addr_sel;
    assign dp.rf_w_sel     = ctrl.rf_w_sel;
    assign dp.rf_r_addr_0  = ctrl.rf_r_addr_0;
    assign dp.rf_r_addr_1  = ctrl.rf_r_addr_1;
    assign dp.rf_w_addr    = ctrl.rf_w_addr;
    assign dp.a_sel        = ctrl.a_sel;
    assign dp.b_sel        = ctrl.b_sel;
    assign dp.imm_sel      = ctrl.imm_sel;
    assign dp.alu_sel      = ctrl.alu_sel;
    assign dp.nzp_sel      = ctrl.nzp_sel;
    assign dp.nzp          = nzp_q;
    assign dp.halted       = (state_q == ST_HALT);

`ifdef PUNC_INSTR_COUNT_EN
    logic [31:0] count_q;
    logic        retire;

    // Final execute cycle: EXEC of a single-phase op (TRAP included) or EXEC2.
    assign retire = !rst && ((state_q == ST_EXEC && !exec_c.two_phase) || state_q == ST_EXEC2);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire && count_q != 32'hFFFF_FFFF) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign retired_count = count_q;
`endif

endmodule

// File: tb/tb_punc_control_fsm.sv
// Bench: a behavioural LC3 datapath obeys the controller's strobes; an instruction-level ISA model
// predicts architectural state, compared at each instruction boundary plus directed literal cases.
module tb_punc_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    punc_control_fsm_if dp_if ();
`ifdef PUNC_INSTR_COUNT_EN
    logic [31:0] retired_count;
`endif

    punc_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .dp            (dp_if)
`ifdef PUNC_INSTR_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    // Bench datapath state
    logic [15:0] b_mem [0:65535];
    logic [15:0] b_rf  [0:7];
    logic [15:0] b_pc, b_ir, b_store;
    logic [15:0] imm, a_val, b_val, alu_y, pc_off, maddr, mdata, wdata, cmp_v;

    // ISA model state
    logic [15:0] m_mem [0:65535];
    logic [15:0] m_rf  [0:7];
    logic [15:0] m_pc;
    logic [2:0]  m_nzp;
    logic        m_halted;
    logic [31:0] m_count;

    int n_checks = 0;
    int n_fail   = 0;
    int w_cnt    = 0;
    int sl_cnt   = 0;

    function automatic logic [15:0] sx(input logic [15:0] x, input int bits);
        logic signed [15:0] s;
        s = x << (16 - bits);
        return s >>> (16 - bits);
    endfunction

    always_comb begin
        case (dp_if.imm_sel)
            2'd0:    imm = sx(b_ir, 5);
            2'd1:    imm = sx(b_ir, 6);
            2'd2:    imm = sx(b_ir, 9);
            default: imm = sx(b_ir, 11);
        endcase
        a_val = dp_if.a_sel ? b_rf[dp_if.rf_r_addr_0] : b_pc;
        b_val = dp_if.b_sel ? imm : b_rf[dp_if.rf_r_addr_1];
        case (dp_if.alu_sel)
            2'd0:    alu_y = a_val + b_val;
            2'd1:    alu_y = a_val & b_val;
            2'd2:    alu_y = a_val;
            default: alu_y = ~a_val;
        endcase
        pc_off = b_pc + (dp_if.pc_add_sel ? sx(b_ir, 9) : sx(b_ir, 11));
        case (dp_if.mem_addr_sel)
            2'd0:    maddr = b_pc;
            2'd1:    maddr = alu_y;
            default: maddr = b_store;
        endcase
        mdata = b_mem[maddr];
        case (dp_if.rf_w_sel)
            2'd0:    wdata = b_pc;
            2'd1:    wdata = mdata;
            default: wdata = alu_y;
        endcase
        cmp_v = dp_if.nzp_sel ? mdata : alu_y;
    end

    assign dp_if.ir    = b_ir;
    assign dp_if.cmp_n = cmp_v[15];
    assign dp_if.cmp_z = (cmp_v == 16'd0);
    assign dp_if.cmp_p = !cmp_v[15] && (cmp_v != 16'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: datapath registers follow the strobes at posedge, results settle by negedge.
    task automatic tick();
        @(posedge clk);
        if (dp_if.pc_clr)      b_pc <= 16'd0;
        else if (dp_if.pc_ld)  b_pc <= dp_if.pc_data_sel ? alu_y : pc_off;
        else if (dp_if.pc_inc) b_pc <= b_pc + 16'd1;
        if (dp_if.ir_ld) b_ir <= mdata;
        if (dp_if.store_ld) begin
            b_store <= mdata;
            sl_cnt++;
        end
        if (dp_if.mem_w_en) begin
            b_mem[maddr] <= b_rf[dp_if.rf_r_addr_1];
            w_cnt++;
        end
        if (dp_if.rf_w_en) b_rf[dp_if.rf_w_addr] <= wdata;
        @(negedge clk);
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] v);
        b_mem[a] <= v;
        m_mem[a] = v;
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        b_rf[r] <= v;
        m_rf[r] = v;
    endtask

    function automatic logic [2:0] cc(input logic [15:0] v);
        return v[15] ? 3'b100 : (v == 16'd0) ? 3'b010 : 3'b001;
    endfunction

    // Executes one whole instruction at ISA level.
    task automatic model_step(output int exp_w, output int exp_sl, output logic [15:0] wa);
        logic [15:0] ir, ea, v, t;
        ir = m_mem[m_pc];
        m_pc = m_pc + 16'd1;
        exp_w = 0; exp_sl = 0; wa = 16'd0;
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                t = ir[5] ? sx(ir, 5) : m_rf[ir[2:0]];
                if (ir[15:12] == 4'h1)      v = m_rf[ir[8:6]] + t;
                else if (ir[15:12] == 4'h5) v = m_rf[ir[8:6]] & t;
                else                        v = ~m_rf[ir[8:6]];
                m_rf[ir[11:9]] = v;
                m_nzp = cc(v);
            end
            4'h0: if ((ir[11] && m_nzp[2]) || (ir[10] && m_nzp[1]) || (ir[9] && m_nzp[0]))
                      m_pc = m_pc + sx(ir, 9);
            4'hC: m_pc = m_rf[ir[8:6]];
            4'h4: begin
                t = m_pc;
                m_pc = ir[11] ? m_pc + sx(ir, 11) : m_rf[ir[8:6]];
                m_rf[7] = t;
            end
            4'h2, 4'h6: begin
                ea = (ir[15:12] == 4'h2) ? m_pc + sx(ir, 9) : m_rf[ir[8:6]] + sx(ir, 6);
                v = m_mem[ea];
                m_rf[ir[11:9]] = v;
                m_nzp = cc(v);
            end
            4'h3, 4'h7: begin
                ea = (ir[15:12] == 4'h3) ? m_pc + sx(ir, 9) : m_rf[ir[8:6]] + sx(ir, 6);
                m_mem[ea] = m_rf[ir[11:9]];
                exp_w = 1; wa = ea;
            end
            4'hE: m_rf[ir[11:9]] = m_pc + sx(ir, 9);
            4'hA: begin
                ea = m_mem[m_pc + sx(ir, 9)];
                v = m_mem[ea];
                m_rf[ir[11:9]] = v;
                m_nzp = cc(v);
                exp_sl = 1;
            end
            4'hB: begin
                ea = m_mem[m_pc + sx(ir, 9)];
                m_mem[ea] = m_rf[ir[11:9]];
                exp_w = 1; exp_sl = 1; wa = ea;
            end
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    endtask

    task automatic run_instr();
        int cyc, w0, s0, exp_w, exp_sl;
        logic [15:0] wa;
        logic [3:0] op;
        op = m_mem[m_pc][15:12];
        cyc = (op == 4'hA || op == 4'hB) ? 4 : 3;
        w0 = w_cnt; s0 = sl_cnt;
        repeat (cyc) tick();
        model_step(exp_w, exp_sl, wa);
        check("pc", {16'd0, b_pc}, {16'd0, m_pc});
        check("nzp", {29'd0, dp_if.nzp}, {29'd0, m_nzp});
        check("halted", {31'd0, dp_if.halted}, {31'd0, m_halted});
        check("at_fetch", {31'd0, dp_if.ir_ld}, {31'd0, !m_halted});
        for (int r = 0; r < 8; r++) check($sformatf("rf%0d", r), {16'd0, b_rf[r]}, {16'd0, m_rf[r]});
        check("mem_w_pulses", w_cnt - w0, exp_w);
        check("store_ld_pulses", sl_cnt - s0, exp_sl);
        if (exp_w != 0) check("mem_data", {16'd0, b_mem[wa]}, {16'd0, m_mem[wa]});
`ifdef PUNC_INSTR_COUNT_EN
        check("retired_count", retired_count, m_count);
`endif
    endtask

    task automatic do_reset();
        logic [15:0] v;
        rst = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            if (v[15:12] == 4'hF) v[15:12] = 4'h1;
            load_word(16'(i), v);
        end
        for (int r = 0; r < 8; r++) set_reg(r, 16'($urandom));
        tick();
        tick();
        check("rst_pc_clr", {31'd0, dp_if.pc_clr}, 32'd1);
        check("rst_no_write", {30'd0, dp_if.mem_w_en, dp_if.rf_w_en}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_pc", {16'd0, b_pc}, 32'd0);
        check("rst_nzp", {29'd0, dp_if.nzp}, 32'b010);
        check("rst_fetch", {30'd0, dp_if.ir_ld, dp_if.halted}, 32'b10);
        m_pc = 16'd0; m_nzp = 3'b010; m_halted = 1'b0; m_count = 32'd0;
`ifdef PUNC_INSTR_COUNT_EN
        check("rst_count", retired_count, 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] saved;
        int w0;

        // ADD R1,R1,#1 with R1=4
        do_reset();
        load_word(16'h0000, 16'h1261);
        set_reg(1, 16'd4);
        run_instr();
        check("add_r1", {16'd0, b_rf[1]}, 32'h5);
        check("add_nzp", {29'd0, dp_if.nzp}, 32'b001);
        check("add_pc", {16'd0, b_pc}, 32'h1);
`ifdef PUNC_INSTR_COUNT_EN
        check("add_count", retired_count, 32'd1);
`endif

        // BRz taken with nzp=010
        do_reset();
        load_word(16'h0000, 16'h0E0F);
        load_word(16'h0010, 16'h0405);
        run_instr();
        run_instr();
        check("brz_taken_pc", {16'd0, b_pc}, 32'h16);

        // BRz not taken with nzp=100
        do_reset();
        load_word(16'h0000, 16'h103F);
        set_reg(0, 16'd0);
        load_word(16'h0001, 16'h0E0E);
        load_word(16'h0010, 16'h0405);
        run_instr();
        run_instr();
        run_instr();
        check("brz_not_taken_pc", {16'd0, b_pc}, 32'h11);

        // LDI R2
        do_reset();
        load_word(16'h0000, 16'hA404);
        load_word(16'h0005, 16'h0040);
        load_word(16'h0040, 16'h8000);
        run_instr();
        check("ldi_r2", {16'd0, b_rf[2]}, 32'h8000);
        check("ldi_nzp", {29'd0, dp_if.nzp}, 32'b100);

        // JSR off11 at 0x20, then JSRR R3
        do_reset();
        load_word(16'h0000, 16'h0E1F);
        load_word(16'h0020, 16'h4803);
        load_word(16'h0024, 16'h40C0);
        set_reg(3, 16'h0100);
        run_instr();
        run_instr();
        check("jsr_r7", {16'd0, b_rf[7]}, 32'h21);
        check("jsr_pc", {16'd0, b_pc}, 32'h24);
        run_instr();
        check("jsrr_pc", {16'd0, b_pc}, 32'h100);
        check("jsrr_r7", {16'd0, b_rf[7]}, 32'h25);

        // Reset during EXEC2 of STI
        do_reset();
        set_reg(0, 16'd0);
        load_word(16'h0000, 16'h103F);
        load_word(16'h0001, 16'hB203);
        load_word(16'h0005, 16'h0050);
        run_instr();
        saved = b_mem[16'h0050];
        w0 = w_cnt;
        repeat (3) tick();
        check("sti_exec2_addr", {30'd0, dp_if.mem_addr_sel}, 32'b10);
        rst = 1'b1;
        #1;
        check("sti_rst_no_w", {31'd0, dp_if.mem_w_en}, 32'd0);
        check("sti_rst_pc_clr", {31'd0, dp_if.pc_clr}, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("sti_rst_pc", {16'd0, b_pc}, 32'd0);
        check("sti_rst_nzp", {29'd0, dp_if.nzp}, 32'b010);
        check("sti_rst_fetch", {31'd0, dp_if.ir_ld}, 32'd1);
        check("sti_rst_mem", {16'd0, b_mem[16'h0050]}, {16'd0, saved});
        check("sti_rst_pulses", w_cnt - w0, 32'd0);

        // TRAP halts and stays quiet
        do_reset();
        load_word(16'h0000, 16'hF025);
        run_instr();
        check("trap_halted", {31'd0, dp_if.halted}, 32'd1);
`ifdef PUNC_INSTR_COUNT_EN
        check("trap_count", retired_count, 32'd1);
`endif
        for (int c = 0; c < 20; c++) begin
            tick();
            check("halt_strobes", {24'd0, dp_if.pc_ld, dp_if.pc_clr, dp_if.pc_inc, dp_if.ir_ld,
                  dp_if.store_ld, dp_if.mem_w_en, dp_if.rf_w_en, dp_if.nzp_ld_dp}, 32'd0);
            check("halt_stays", {31'd0, dp_if.halted}, 32'd1);
        end

        // Random programs
        for (int seg = 0; seg < 20; seg++) begin
            do_reset();
            for (int k = 0; k < 80; k++) begin
                if (m_halted) break;
                run_instr();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/punc_control_fsm.md
Name: punc_control_fsm

Overview:
- Multi-cycle control FSM for the PUnC LC3 processor; sequences the datapath (PC, IR, store register, register file, memory, ALU) through fetch/decode/execute.
- Owns the NZP condition-code register and makes the branch decision.
- Every datapath control strobe comes from this block. The datapath provides IR and comparator results only.

Parameters:
- none (LC3 ISA widths fixed at 16/3 bits; shared encodings live in the package)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-high
- ir  in  16  IR contents from datapath
- cmp_n / cmp_z / cmp_p  in  1 each  datapath comparator outputs (signed <0, ==0, >0 of nzp-selected value)
- pc_ld, pc_clr, pc_inc, ir_ld, store_ld, mem_w_en, rf_w_en, nzp_ld_dp  out  1 each  datapath load/write strobes
- pc_data_sel  out  1  0=PC+offset, 1=ALU result (base register)
- pc_add_sel  out  1  0=offset11, 1=offset9
- mem_addr_sel  out  2  00=PC, 01=ALU, 10=store register
- rf_w_sel  out  2  00=PC, 01=memory data, 10=ALU
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  out  3 each  register file addresses
- a_sel  out  1  0=PC, 1=RF port 0
- b_sel  out  1  0=RF port 1, 1=sign-extended immediate
- imm_sel  out  2  00=imm5, 01=offset6, 10=offset9, 11=offset11
- alu_sel  out  2  00=ADD, 01=AND, 10=PASS_A, 11=NOT
- nzp_sel  out  1  0=ALU result, 1=memory data
- nzp  out  3  current condition codes {N,Z,P}
- halted  out  1  high in HALT state

Behaviour:
- States: FETCH, DECODE, EXEC, EXEC2, HALT. State register updates on posedge clk. All strobes are decoded combinationally from state and ir. Strobes default to 0 in every state unless listed.
- Reset: state=FETCH, nzp=3'b010. pc_clr is asserted combinationally while rst=1. rst overrides any in-flight instruction, including EXEC2 of LDI/STI, and no memory or RF write occurs in that cycle.
- FETCH: mem_addr_sel=PC, ir_ld=1, pc_inc=1 -> DECODE.
- DECODE: no strobes. Lets IR settle -> EXEC.
- EXEC, by ir[15:12]:
  - ADD(0001)/AND(0101): r0=ir[8:6], a_sel=RF. If ir[5]=1: b_sel=imm, imm_sel=imm5; else r1=ir[2:0]. rf_w_sel=ALU, w_addr=ir[11:9], rf_w_en, nzp_sel=ALU, nzp_ld.
  - NOT(1001): as above with alu_sel=NOT and no B operand.
  - BR(0000): taken=(ir[11]&N)|(ir[10]&Z)|(ir[9]&P). If taken: pc_ld, pc_data_sel=PC+off, pc_add_sel=off9.
  - JMP(1100): r0=ir[8:6], alu=PASS_A, pc_data_sel=ALU, pc_ld.
  - JSR(0100): rf_w_sel=PC, w_addr=7, rf_w_en, pc_ld. If ir[11]=1: pc_add_sel=off11, PC+off. Else base register ir[8:6] via PASS_A. R7 receives the already-incremented PC because the RF write and PC load share one edge.
  - LD(0010): a_sel=PC, imm off9, ADD, mem_addr_sel=ALU, rf_w_sel=MEM, rf_w_en, nzp_sel=MEM, nzp_ld.
  - LDR(0110): same as LD but a_sel=RF, r0=ir[8:6], off6.
  - ST(0011)/STR(0111): same addressing as LD/LDR. r1=ir[11:9], mem_w_en.
  - LEA(1110): PC+off9 via ALU, rf_w_sel=ALU, rf_w_en. Does not load nzp.
  - LDI(1010)/STI(1011): PC+off9 address, store_ld=1 (store captures memory read data) -> EXEC2.
  - TRAP(1111): -> HALT.
  - RTI(1000), reserved(1101): no-op.
  - All other cases -> FETCH.
- EXEC2: mem_addr_sel=STORE.
  - LDI: rf_w_sel=MEM, rf_w_en, nzp_ld with nzp_sel=MEM.
  - STI: r1=ir[11:9], mem_w_en.
  - -> FETCH.
- nzp register loads {cmp_n,cmp_z,cmp_p} on the cycle nzp_ld_dp is high. The one-hot value is preserved, with no re-encoding.
- HALT: all strobes 0, halted=1. Exit only by rst.
- Cycle counts: 3 cycles per instruction; LDI/STI take 4.

Optional Feature:
- PUNC_INSTR_COUNT_EN defined: adds output retired_count [31:0].
  - Reset to 0.
  - Increments by 1 on the final execute cycle of each instruction (EXEC not going to EXEC2, or EXEC2). TRAP counts once.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package punc_ctrl_pkg holds:
  - state encodings
  - 4-bit opcode constants
  - all select encodings (mem_addr_sel, rf_w_sel, alu_sel, imm_sel, a/b/pc/nzp sels)
- One natural sub-module: punc_ctrl_decode. Combinational; ir -> per-opcode control bundle. The FSM gates the bundle by state.

Test Plan:
- Reset then FETCH with mem[0]=16'h1261 (ADD R1,R1,#1), R1=4: R1=5 after 3 cycles, nzp=001, pc=1.
- BRz with nzp=010, off9=+5, PC=0x0011 after fetch: PC=0x0016. Same with nzp=100: PC unchanged at 0x0011.
- LDI R2 with mem[PC+off9]=0x0040, mem[0x40]=16'h8000: after 4 cycles R2=16'h8000, nzp=100, store_ld seen exactly once.
- JSR off11=+3 at address 0x0020: R7=0x0021, PC=0x0024. JSRR R3=0x0100: PC=0x0100.
- rst asserted during EXEC2 of STI: no mem_w_en pulse, state=FETCH, pc=0, nzp=010 on the next cycle.
- TRAP (16'hF025): halted=1 and all strobes stay 0 for 20 cycles. With PUNC_INSTR_COUNT_EN, retired_count equals the instruction count executed.
